// File: rtl/cc3_frame_sequencer.sv
// cc3_frame_sequencer: frame controller and noise arbiter for the rate-1/2, K=3 convolutional encoder
// Ports: clock, reset (synchronous, active-high); start begins a frame from IDLE;
//   msg_valid/msg_bit/msg_ready carry message bits over a valid/ready handshake;
//   enc_in/enc_shift/enc_clear drive the encoder; frame_active/frame_done report frame status;
//   noise0_req/noise1_req request corruption of out1/out2, noise0/noise1 are the grants;
//   grant_cnt counts errors granted in the current frame (saturating).
// Define CC3_TAIL_FLUSH_EN to build the TAIL state that shifts TAIL_LEN zeros to flush the encoder.
module cc3_frame_sequencer #(
    parameter int FRAME_LEN = 8,
    parameter int TAIL_LEN  = 2,
    parameter int NOISE_GAP = 3
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    input  logic       msg_valid,
    input  logic       msg_bit,
    output logic       msg_ready,
    output logic       enc_in,
    output logic       enc_shift,
    output logic       enc_clear,
    output logic       frame_active,
    output logic       frame_done,
    input  logic       noise0_req,
    input  logic       noise1_req,
    output logic       noise0,
    output logic       noise1,
    output logic [3:0] grant_cnt
);
    typedef enum logic [2:0] {IDLE, CLEAR, DATA, TAIL, DONE} state_t;
`ifdef CC3_TAIL_FLUSH_EN
    localparam state_t DATA_EXIT = TAIL;
`else
    localparam state_t DATA_EXIT = DONE;
`endif
    state_t     state, state_nxt;
    logic [7:0] bit_cnt;
    logic [3:0] tail_cnt;
    logic [3:0] gap_cnt;
    logic       rr_ptr;
    logic       grant_ok;
    logic       last_bit;
    always_comb begin
        msg_ready    = state == DATA;
        enc_shift    = (state == DATA && msg_valid) || state == TAIL;
        enc_in       = state == DATA && msg_valid && msg_bit;
        enc_clear    = state == CLEAR;
        frame_done   = state == DONE;
        frame_active = state inside {CLEAR, DATA, TAIL};
        grant_ok     = enc_shift && gap_cnt == 4'd0;
        // rr_ptr=0 favours noise0 when both request; a lone requester always wins
        noise0       = grant_ok && noise0_req && (!noise1_req || !rr_ptr);
        noise1       = grant_ok && noise1_req && (!noise0_req || rr_ptr);
        last_bit     = bit_cnt == 8'(FRAME_LEN - 1);
        state_nxt    = state;
        case (state)
            IDLE:    state_nxt = start ? CLEAR : IDLE;
            CLEAR:   state_nxt = DATA;
            DATA:    state_nxt = (msg_valid && last_bit) ? DATA_EXIT : DATA;
            TAIL:    state_nxt = (tail_cnt == 4'(TAIL_LEN - 1)) ? DONE : TAIL;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end
    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            bit_cnt   <= '0;
            tail_cnt  <= '0;
            gap_cnt   <= '0;
            grant_cnt <= '0;
            rr_ptr    <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == CLEAR) begin
                bit_cnt   <= '0;
                tail_cnt  <= '0;
                gap_cnt   <= '0;
                grant_cnt <= '0;
            end else begin
                if (state == DATA && msg_valid)
                    bit_cnt <= bit_cnt + 8'd1;
                if (state == TAIL)
                    tail_cnt <= tail_cnt + 4'd1;
                // a grant reopens the quiet window; only shifted symbols count it down
                if (noise0 || noise1) begin
                    gap_cnt   <= 4'(NOISE_GAP);
                    grant_cnt <= grant_cnt + {3'b000, grant_cnt != 4'hF};
                    rr_ptr    <= noise0;
                end else if (enc_shift && gap_cnt != 4'd0) begin
                    gap_cnt <= gap_cnt - 4'd1;
                end
            end
        end
    end
endmodule

// File: tb/tb_cc3_frame_sequencer.sv
// tb_cc3_frame_sequencer: scoreboard bench for cc3_frame_sequencer against a symbol-level reference model
module tb_cc3_frame_sequencer;
    localparam int FRAME_LEN = 8;
    localparam int TAIL_LEN  = 2;
    localparam int NOISE_GAP = 3;
`ifdef CC3_TAIL_FLUSH_EN
    localparam int TAIL_CYC = TAIL_LEN;
`else
    localparam int TAIL_CYC = 0;
`endif
    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       msg_valid = 1'b0;
    logic       msg_bit = 1'b0;
    logic       noise0_req = 1'b0;
    logic       noise1_req = 1'b0;
    logic       msg_ready, enc_in, enc_shift, enc_clear, frame_active, frame_done, noise0, noise1;
    logic [3:0] grant_cnt;
    int          checks = 0;
    int          errors = 0;
    int unsigned cyc = 0;
    typedef struct packed {logic ready; logic din; logic n0; logic n1;} sym_t;
    typedef struct packed {logic [31:0] at; logic [3:0] gcnt;} done_t;
    sym_t        sym_q[$];
    done_t       done_q[$];
    logic [31:0] clr_q[$];
    // reference model state: preferred requester, symbol index in frame, index of last grant
    logic rr = 1'b0;
    int   sym_idx, last_grant, grants;

    cc3_frame_sequencer #(.FRAME_LEN(FRAME_LEN), .TAIL_LEN(TAIL_LEN), .NOISE_GAP(NOISE_GAP)) dut (
        .clock(clock), .reset(reset), .start(start), .msg_valid(msg_valid), .msg_bit(msg_bit),
        .msg_ready(msg_ready), .enc_in(enc_in), .enc_shift(enc_shift), .enc_clear(enc_clear),
        .frame_active(frame_active), .frame_done(frame_done), .noise0_req(noise0_req),
        .noise1_req(noise1_req), .noise0(noise0), .noise1(noise1), .grant_cnt(grant_cnt)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at cycle %0d", name, act, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // A grant is possible only when more than NOISE_GAP symbols separate it from the previous one.
    function automatic void model_sym(input logic ready, input logic din, input logic r0, input logic r1);
        logic g0, g1;
        sym_idx++;
        g0 = 1'b0;
        g1 = 1'b0;
        if ((r0 || r1) && sym_idx - last_grant > NOISE_GAP) begin
            if (r0 && r1) begin
                g0 = !rr;
                g1 = rr;
            end else begin
                g0 = r0;
                g1 = r1;
            end
            rr = g0;
            last_grant = sym_idx;
            if (grants < 15) grants++;
        end
        sym_q.push_back(sym_t'{ready: ready, din: din, n0: g0, n1: g1});
    endfunction

    task automatic drive_idle(input int mode);
        msg_valid  = mode == 1 ? 1'b1 : 1'($urandom);
        msg_bit    = 1'($urandom);
        noise0_req = mode == 1 ? 1'b1 : 1'($urandom);
        noise1_req = mode == 1 ? 1'b1 : 1'($urandom);
    endtask

    task automatic check_reset_outputs();
        chk("rst_msg_ready", msg_ready, 0);
        chk("rst_enc_in", enc_in, 0);
        chk("rst_enc_shift", enc_shift, 0);
        chk("rst_enc_clear", enc_clear, 0);
        chk("rst_frame_active", frame_active, 0);
        chk("rst_frame_done", frame_done, 0);
        chk("rst_noise0", noise0, 0);
        chk("rst_noise1", noise1, 0);
        chk("rst_grant_cnt", grant_cnt, 0);
    endtask

    // mode 0: random; mode 1: fixed pattern, requests always high, optional stall on bit 3;
    // mode 2: requests only on the third symbol, reset after four accepts.
    task automatic run_frame(input int mode, input int stall_len);
        int          acc, stalls, stalled;
        int unsigned t0;
        logic        b, r0, r1, stall;
        logic [7:0]  pat = 8'b0100_1101;
        drive_idle(mode);
        start = 1'b1;
        t0 = cyc;
        step();
        start = 1'b0;
        drive_idle(mode);
        clr_q.push_back(32'(t0 + 1));
        sym_idx = 0;
        last_grant = -100;
        grants = 0;
        step();
        acc = 0;
        stalls = 0;
        stalled = 0;
        while (acc < FRAME_LEN) begin
            stall = mode == 1 ? (acc == 2 && stalled < stall_len) : mode == 0 ? ($urandom_range(3, 0) == 0) : 1'b0;
            b  = mode == 0 ? 1'($urandom) : pat[acc % 8];
            r0 = mode == 1 ? 1'b1 : mode == 2 ? (acc == 2) : 1'($urandom);
            r1 = mode == 1 ? 1'b1 : mode == 2 ? (acc == 2) : 1'($urandom);
            msg_valid  = !stall;
            msg_bit    = stall ? 1'($urandom) : b;
            noise0_req = r0;
            noise1_req = r1;
            if (stall) begin
                stalls++;
                stalled++;
            end else begin
                model_sym(1'b1, b, r0, r1);
                acc++;
            end
            step();
            if (mode == 2 && acc == 4) begin
                msg_valid  = 1'b0;
                noise0_req = 1'b0;
                noise1_req = 1'b0;
                reset = 1'b1;
                step();
                check_reset_outputs();
                reset = 1'b0;
                rr = 1'b0;
                return;
            end
        end
        for (int i = 0; i < TAIL_CYC; i++) begin
            drive_idle(mode);
            model_sym(1'b0, 1'b0, noise0_req, noise1_req);
            step();
        end
        done_q.push_back(done_t'{at: 32'(t0 + 2 + FRAME_LEN + stalls + TAIL_CYC), gcnt: 4'(grants)});
        drive_idle(mode);
        start = 1'b1;
        step();
        start = 1'b0;
        drive_idle(mode);
        step();
    endtask

    always @(negedge clock) begin : monitor
        sym_t        s;
        done_t       d;
        logic [31:0] ca;
        if (!reset) begin
            chk("grant_exclusive", {31'd0, noise0 & noise1}, 0);
            if (!enc_shift) chk("grant_without_shift", {31'd0, noise0 | noise1}, 0);
            if (!frame_active) chk("ready_inactive", msg_ready, 0);
            if (enc_shift) begin
                if (sym_q.size() == 0) begin
                    chk("unexpected_shift", 1, 0);
                end else begin
                    s = sym_q.pop_front();
                    chk("msg_ready", msg_ready, s.ready);
                    chk("enc_in", enc_in, s.din);
                    chk("noise0", noise0, s.n0);
                    chk("noise1", noise1, s.n1);
                    chk("active_on_shift", frame_active, 1);
                end
            end
            if (enc_clear) begin
                if (clr_q.size() == 0) begin
                    chk("unexpected_clear", 1, 0);
                end else begin
                    ca = clr_q.pop_front();
                    chk("clear_cycle", cyc, ca);
                    chk("clear_no_shift", enc_shift, 0);
                end
            end
            if (frame_done) begin
                if (done_q.size() == 0) begin
                    chk("unexpected_done", 1, 0);
                end else begin
                    d = done_q.pop_front();
                    chk("done_cycle", cyc, d.at);
                    chk("grant_cnt", grant_cnt, d.gcnt);
                    chk("done_inactive", frame_active, 0);
                end
            end
        end
    end

    initial begin
        drive_idle(0);
        start = 1'b1;
        repeat (3) step();
        check_reset_outputs();
        reset = 1'b0;
        start = 1'b0;
        step();
        run_frame(1, 0);
        run_frame(1, 4);
        run_frame(2, 0);
        run_frame(0, 0);
        repeat (25) run_frame(0, 0);
        repeat (3) step();
        chk("pending_symbols", sym_q.size(), 0);
        chk("pending_done", done_q.size(), 0);
        chk("pending_clear", clr_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
